// File: rtl/capture_seq.sv
// capture_seq: ADC acquisition sequencer handling trigger, holdoff, decimation and the two-bank swap handshake.
// Define CAPTURE_SEQ_AUTO_TRIG_EN to build the auto-mode timeout counter and the auto_fired flag.
module capture_seq #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUF_SIZE     = 1024,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        reg_wr,
  input  logic                        reg_rd,
  input  logic [15:0]                 reg_addr,
  input  logic [DATA_WIDTH-1:0]       reg_wdata,
  output logic [DATA_WIDTH-1:0]       reg_rdata,
  input  logic                        stable,
  input  logic                        trig_in,
  input  logic                        sample_tick,
  output logic                        smp_we,
  output logic [$clog2(BUF_SIZE)-1:0] smp_addr,
  output logic                        wr_bank,
  output logic                        irq
);
  localparam int AW = $clog2(BUF_SIZE);
  typedef enum logic [2:0] {IDLE, ARM, HOLDOFF, WAIT_TRIG, CAPTURE, HANDOFF} state_t;
  state_t state, state_nx;
  logic run, single, ready, overrun, auto_fired, trig_prev;
  logic [1:0] mode;
  logic [DATA_WIDTH-1:0] decim, decim_len, hold_len, hold_cnt, dcnt;
  logic wr_ctrl, wr_stat, run_clr, release_bank, abort, last, timeout;
  logic edge_hit, forced, trig_hit, take, swap, hold_done;
  assign wr_ctrl      = reg_wr && reg_addr == 16'h4000;
  assign wr_stat      = reg_wr && reg_addr == 16'h4002;
  assign run_clr      = wr_ctrl && !reg_wdata[0];
  assign release_bank = wr_stat && reg_wdata[0];
  assign abort        = !stable && (state == HOLDOFF || state == WAIT_TRIG || state == CAPTURE);
  assign last         = smp_we && smp_addr == AW'(BUF_SIZE - 1);
  assign irq          = ready;
`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT) + 1;
  logic [TW-1:0] tcnt;
  assign timeout = tcnt == TW'(AUTO_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else if (state != WAIT_TRIG) tcnt <= '0;
    else if (!timeout) tcnt <= tcnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    edge_hit  = mode == 2'b01 ? trig_prev && !trig_in : mode == 2'b11 ? 1'b1 : !trig_prev && trig_in;
    forced    = mode == 2'b10 && timeout;
    trig_hit  = sample_tick && (edge_hit || forced);
    take      = sample_tick && dcnt == decim_len && !last;
    swap      = !ready || release_bank;
    hold_done = hold_cnt == '0 || (sample_tick && hold_cnt == DATA_WIDTH'(1));
    state_nx  = state;
    case (state)
      IDLE:      state_nx = run ? ARM : IDLE;
      ARM:       state_nx = HOLDOFF;
      HOLDOFF:   state_nx = hold_done ? WAIT_TRIG : HOLDOFF;
      WAIT_TRIG: state_nx = trig_hit ? CAPTURE : WAIT_TRIG;
      CAPTURE:   state_nx = last ? HANDOFF : CAPTURE;
      HANDOFF:   state_nx = single ? (swap ? IDLE : HANDOFF) : ARM;
      default:   state_nx = IDLE;
    endcase
    if (abort) state_nx = ARM;
    if (run_clr) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {run, single, mode, ready, overrun, auto_fired, trig_prev, smp_we, wr_bank} <= '0;
      {decim, decim_len, hold_len, hold_cnt, dcnt, reg_rdata} <= '0;
      smp_addr <= '0;
    end else begin
      if (sample_tick) trig_prev <= trig_in;
      if (wr_ctrl) {mode, single, run} <= reg_wdata[3:0];
      if (reg_wr && reg_addr == 16'h4001) decim <= reg_wdata;
      if (reg_wr && reg_addr == 16'h4003) hold_len <= reg_wdata;
      if (release_bank) ready <= 1'b0;
      if (wr_stat && reg_wdata[1]) overrun <= 1'b0;
      if (reg_rd)
        reg_rdata <= reg_addr == 16'h4000 ? DATA_WIDTH'({mode, single, run}) :
                     reg_addr == 16'h4001 ? decim :
                     reg_addr == 16'h4002 ? DATA_WIDTH'({state, auto_fired, overrun, ready}) :
                     reg_addr == 16'h4003 ? hold_len : '1;
      smp_we <= 1'b0;
      case (state)
        ARM: begin
          hold_cnt  <= hold_len;
          decim_len <= decim;
          smp_addr  <= '0;
        end
        HOLDOFF: if (sample_tick && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        WAIT_TRIG: if (trig_hit) begin
          smp_we     <= 1'b1;
          dcnt       <= '0;
          auto_fired <= forced && !edge_hit;
        end
        CAPTURE: begin
          smp_addr <= smp_addr + AW'(smp_we);
          smp_we   <= take;
          if (sample_tick) dcnt <= dcnt == decim_len ? '0 : dcnt + 1'b1;
        end
        HANDOFF: begin
          // A release landing in this cycle counts as a free bank, so the swap wins.
          if (swap) begin
            wr_bank <= !wr_bank;
            ready   <= 1'b1;
            if (single) run <= 1'b0;
          end else if (!single) overrun <= 1'b1;
        end
        default: ;
      endcase
      if (abort || run_clr) smp_we <= 1'b0;
      if (abort) smp_addr <= '0;
    end
  end
endmodule

// File: doc/capture_seq.md
# capture_seq

Acquisition sequencer for the ADC capture path. Decides when a capture starts (trigger mode, holdoff, auto-timeout) and at what rate samples are taken (decimation). Generates write strobes and addresses into a two-bank sample RAM, and owns the bank-swap handshake with the MCU over the FSMC register bus. Sits between the synchronized ADC/comparator signals and the dual-bank RAM. Replaces ad-hoc trigger and swap logic inside the buffer.

## Interface
- DATA_WIDTH, 16, FSMC register data width
- BUF_SIZE, 1024, samples per bank (power of two)
- AUTO_TIMEOUT, 1000000, clk cycles in WAIT_TRIG before forced trigger (auto mode)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- reg_wr  in  1  one-cycle register write strobe
- reg_rd  in  1  one-cycle register read strobe
- reg_addr  in  16  register address
- reg_wdata  in  DATA_WIDTH  write data
- reg_rdata  out  DATA_WIDTH  read data, registered
- stable  in  1  signal-conditioning stable flag (synchronized)
- trig_in  in  1  comparator square wave (synchronized)
- sample_tick  in  1  one-cycle pulse per ADC sample
- smp_we  out  1  sample RAM write enable, one cycle
- smp_addr  out  $clog2(BUF_SIZE)  write address
- wr_bank  out  1  bank being written; MCU reads bank ~wr_bank
- irq  out  1  level, high while STATUS.ready = 1

## Operation
- Registers:
  - 0x4000 CTRL (rw): bit0 run; bit1 single; bits3:2 mode (00 rising, 01 falling, 10 auto, 11 immediate).
  - 0x4001 DECIM (rw): take one of every DECIM+1 ticks.
  - 0x4002 STATUS: bit0 ready, bit1 overrun (sticky), bit2 auto_fired, bits5:3 state code. Writing 1 to bit0 releases the bank; writing 1 to bit1 clears overrun.
  - 0x4003 HOLDOFF (rw): sample ticks ignored after ARM.
  - All other addresses read 0xFFFF; writes to them are ignored.
- Reset values: all registers 0, state IDLE, wr_bank 0, smp_we 0, smp_addr 0, reg_rdata 0, irq 0.
- State codes: IDLE 0, ARM 1, HOLDOFF 2, WAIT_TRIG 3, CAPTURE 4, HANDOFF 5.
- IDLE: go to ARM when run = 1.
- ARM: load the holdoff counter and go to HOLDOFF.
- HOLDOFF: count sample_ticks. Go to WAIT_TRIG after HOLDOFF ticks; with HOLDOFF = 0, go on the next cycle.
- WAIT_TRIG: a trigger is evaluated only on sample_tick, comparing trig_in with its value at the previous tick.
  - Rising: 0→1. Falling: 1→0. Immediate: first tick.
  - Auto: edge as in rising, or timeout expiry (sets auto_fired).
  - The triggering tick itself is written at addr 0, and the decimation counter restarts.
- CAPTURE: smp_we pulses on every (DECIM+1)th tick; smp_addr increments after each write.
  - The write at addr BUF_SIZE-1 moves the FSM to HANDOFF on the next cycle.
- HANDOFF:
  - If ready = 0: toggle wr_bank, set ready, then go to IDLE if single (run is also cleared), else ARM.
  - If ready = 1 and continuous: set overrun, keep wr_bank, go to ARM (the bank is overwritten).
  - If ready = 1 and single: wait in HANDOFF until released.
- Aborts:
  - stable = 0 in HOLDOFF, WAIT_TRIG or CAPTURE → ARM; the partial capture is discarded and smp_addr is reset.
  - run cleared by a write → IDLE next cycle from any state. smp_we is forced low; ready and wr_bank are kept.
- Simultaneous events:
  - A release write in the same cycle as a HANDOFF evaluation is treated as ready = 0, and the swap proceeds.
  - A reg_wr to DECIM during CAPTURE takes effect at the next ARM.

## Timing
- reg_rdata is valid the cycle after reg_rd and holds until the next reg_rd.
- A register write is effective the cycle after reg_wr.
- smp_we and smp_addr are registered: they assert one clk after the qualifying sample_tick.
- Trigger tick → addr 0 write: 1 clk.
- Last write → wr_bank toggle and ready = 1: 2 clk.
- Timeout counter counts clk cycles from WAIT_TRIG entry; trigger is forced at count AUTO_TIMEOUT-1, on the next sample_tick.
- Back-to-back sample_ticks (every clk) must be supported.

## Configuration
- CAPTURE_SEQ_AUTO_TRIG_EN defined: the timeout counter and auto_fired are implemented.
- Not defined: mode 10 behaves exactly as rising; auto_fired reads 0; no timeout counter is synthesized.

## Test plan
- Rising trigger: CTRL = 0x0001, DECIM = 0, HOLDOFF = 0, trig 0→1 at tick 5.
  - Required: 1024 consecutive writes, addr 0..1023, starting 1 clk after tick 5; then wr_bank = 1, ready = 1, irq = 1.
- Decimation: DECIM = 3.
  - Required: smp_we only on every 4th tick; the 1024th write occurs 4092 ticks after the trigger.
- Overrun: continuous mode, never release.
  - Required: second capture completes, overrun = 1, wr_bank stays 1.
  - Then write STATUS = 0x0003: ready = 0, overrun = 0; next capture toggles wr_bank to 0.
- Single-shot hold: CTRL = 0x0003, ready left at 1 before the trigger.
  - Required: FSM stays in HANDOFF (STATUS[5:3] = 5) until STATUS = 0x0001 is written; then swap, run = 0, IDLE.
- Abort: stable dropped at addr 500.
  - Required: smp_we stops and smp_addr = 0; the next trigger restarts the write at addr 0; wr_bank unchanged.
- Auto mode (macro defined, AUTO_TIMEOUT = 100), no edges on trig_in.
  - Required: capture starts at the first tick after 100 clk; auto_fired = 1.
